// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad configuration sequencer: default sizes,
// register-file addressing and the sequencer state encoding.
package gpio_cfg_pkg;

  localparam int NUM_IO_HALF_DEF = 19;
  localparam int CFG_W_DEF       = 13;
  localparam int CLK_DIV_DEF     = 4;

  localparam int ADDR_W = 6;
  // Register-file address of the io[0] config word; io[n] sits at base + n.
  localparam logic [ADDR_W-1:0] CFG_BASE_ADDR = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_LATCH,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_e;

  function automatic logic [ADDR_W-1:0] pad_addr(input int pad);
    return CFG_BASE_ADDR + ADDR_W'(pad);
  endfunction

endpackage

// File: rtl/gpio_cfg_bitclk.sv
// Phase divider: counts 2*CLK_DIV cycles per serial bit while run is high and
// flags the cycle before serial_clock rises and the last cycle of the bit.
module gpio_cfg_bitclk #(
  parameter int CLK_DIV = 4
) (
  input  logic wb_clk_i,
  input  logic wb_rstn_i,
  input  logic run,
  output logic rise_tick,
  output logic bit_end_tick
);

  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam logic [PW-1:0] RISE_PH = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] END_PH  = PW'(2 * CLK_DIV - 1);

  logic [PW-1:0] phase;

  assign rise_tick    = run && (phase == RISE_PH);
  assign bit_end_tick = run && (phase == END_PH);

  // Phase restarts at every bit boundary and whenever the divider is idle.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i)                phase <= '0;
    else if (!run || bit_end_tick) phase <= '0;
    else                           phase <= phase + PW'(1);
  end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Serial configuration sequencer for the two mprj_io control chains.
// Build option: define GPIO_CFG_PRE_RESET_EN to pulse serial_resetn low before each transfer.
module gpio_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_IO_HALF = NUM_IO_HALF_DEF,
  parameter int CFG_W       = CFG_W_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cfg_addr_1,
  input  logic [CFG_W-1:0]  cfg_data_1,
  output logic [ADDR_W-1:0] cfg_addr_2,
  input  logic [CFG_W-1:0]  cfg_data_2,
  output logic              serial_clock,
  output logic              serial_load,
  output logic              serial_resetn,
  output logic              serial_data_1,
  output logic              serial_data_2
);

  localparam int BW = $clog2(CFG_W) + 1;
  localparam int KW = $clog2(NUM_IO_HALF) + 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(CFG_W - 1);
  localparam logic [KW-1:0] LAST_WORD = KW'(NUM_IO_HALF - 1);

  state_e          state, state_next;
  logic [KW-1:0]   k, k_next;
  logic [BW-1:0]   bit_cnt;
  logic [CFG_W-1:0] sr_1, sr_2;
  logic            run, rise_tick, bit_end_tick, last_bit;

  assign run      = (state == S_CLR) || (state == S_SHIFT) || (state == S_LOAD);
  assign last_bit = (bit_cnt == LAST_BIT);

  gpio_cfg_bitclk #(.CLK_DIV(CLK_DIV)) u_bitclk (
    .wb_clk_i     (wb_clk_i),
    .wb_rstn_i    (wb_rstn_i),
    .run          (run),
    .rise_tick    (rise_tick),
    .bit_end_tick (bit_end_tick)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  // NOTE: defaults first, so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_next = state;
    k_next     = k;
    case (state)
      S_IDLE: begin
        if (start) begin
          k_next = '0;
`ifdef GPIO_CFG_PRE_RESET_EN
          state_next = S_CLR;
`else
          state_next = S_FETCH;
`endif
        end
      end
      S_CLR:   if (bit_end_tick) state_next = S_FETCH;
      S_FETCH: state_next = S_LATCH;
      S_LATCH: state_next = S_SHIFT;
      S_SHIFT: begin
        if (bit_end_tick && last_bit) begin
          k_next     = k + KW'(1);
          state_next = (k == LAST_WORD) ? S_LOAD : S_FETCH;
        end
      end
      S_LOAD:  if (bit_end_tick) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      serial_load   <= 1'b0;
      serial_resetn <= 1'b0;
      serial_clock  <= 1'b0;
      cfg_addr_1    <= '0;
      cfg_addr_2    <= '0;
    end else begin
      busy        <= (state_next != S_IDLE);
      done        <= (state_next == S_DONE);
      serial_load <= (state_next == S_LOAD);
`ifdef GPIO_CFG_PRE_RESET_EN
      serial_resetn <= (state_next != S_CLR);
`else
      serial_resetn <= 1'b1;
`endif
      serial_clock <= (state == S_SHIFT) && (rise_tick || (serial_clock && !bit_end_tick));
      if (state_next == S_FETCH) begin
        cfg_addr_1 <= pad_addr(NUM_IO_HALF - 1 - int'(k_next));
        cfg_addr_2 <= pad_addr(NUM_IO_HALF + int'(k_next));
      end
    end
  end

  // NOTE: the shift registers are reset so the serial data lines idle low; they are flops, not RAM.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      bit_cnt <= '0;
      sr_1    <= '0;
      sr_2    <= '0;
    end else if (state == S_LATCH) begin
      bit_cnt <= '0;
      sr_1    <= cfg_data_1;
      sr_2    <= cfg_data_2;
    end else if (state == S_SHIFT && bit_end_tick && !last_bit) begin
      // The last bit is held so the data lines stay put between words.
      bit_cnt <= bit_cnt + BW'(1);
      sr_1    <= {sr_1[CFG_W-2:0], 1'b0};
      sr_2    <= {sr_2[CFG_W-2:0], 1'b0};
    end
  end

  assign serial_data_1 = sr_1[CFG_W-1];
  assign serial_data_2 = sr_2[CFG_W-1];

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Directed bench for gpio_cfg_sequencer: table of whole-transfer scenarios on a
// CLK_DIV=4 and a CLK_DIV=1 instance, plus reset and mid-transfer abort sequences.
module tb_gpio_cfg_sequencer;

  localparam int N = 19;
  localparam int W = 13;
`ifdef GPIO_CFG_PRE_RESET_EN
  localparam int CLR_EN = 1;
`else
  localparam int CLR_EN = 0;
`endif

  typedef struct {
    string name;
    int    pattern;
    bit    fast;
    bit    restart;
    int    cd;
    int    exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s = 1'b0, start_f = 1'b0;

  logic busy_s, done_s, sc_s, sl_s, srn_s, sd1_s, sd2_s;
  logic busy_f, done_f, sc_f, sl_f, srn_f, sd1_f, sd2_f;
  logic [5:0]  a1_s, a2_s, a1_f, a2_f;
  logic [12:0] d1_s, d2_s, d1_f, d2_f;
  logic [12:0] mem [0:63];

  logic sel_f = 1'b0;
  logic m_busy, m_done, m_sc, m_load, m_rstn, m_sd1, m_sd2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gpio_cfg_sequencer #(.CLK_DIV(4)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
    .cfg_addr_1(a1_s), .cfg_data_1(d1_s), .cfg_addr_2(a2_s), .cfg_data_2(d2_s),
    .serial_clock(sc_s), .serial_load(sl_s), .serial_resetn(srn_s),
    .serial_data_1(sd1_s), .serial_data_2(sd2_s)
  );

  gpio_cfg_sequencer #(.CLK_DIV(1)) dut_f (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .start(start_f), .busy(busy_f), .done(done_f),
    .cfg_addr_1(a1_f), .cfg_data_1(d1_f), .cfg_addr_2(a2_f), .cfg_data_2(d2_f),
    .serial_clock(sc_f), .serial_load(sl_f), .serial_resetn(srn_f),
    .serial_data_1(sd1_f), .serial_data_2(sd2_f)
  );

  // Register file model: read data valid one cycle after the address.
  always @(posedge clk) begin
    d1_s <= mem[a1_s];
    d2_s <= mem[a2_s];
    d1_f <= mem[a1_f];
    d2_f <= mem[a2_f];
  end

  always_comb begin
    m_busy = sel_f ? busy_f : busy_s;
    m_done = sel_f ? done_f : done_s;
    m_sc   = sel_f ? sc_f   : sc_s;
    m_load = sel_f ? sl_f   : sl_s;
    m_rstn = sel_f ? srn_f  : srn_s;
    m_sd1  = sel_f ? sd1_f  : sd1_s;
    m_sd2  = sel_f ? sd2_f  : sd2_s;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pattern);
    for (int a = 0; a < 64; a++) begin
      if (pattern == 0)  mem[a] = 13'h1000 | 13'(a);
      else if (a < N)    mem[a] = 13'h1FFF;
      else               mem[a] = 13'h0000;
    end
  endtask

  task automatic run_transfer(input vec_t v);
    int lat = -1, rises = 0, hi_cyc = 0, load_cyc = 0, load_pulses = 0, done_pulses = 0;
    int busy_err = 0, ovl = 0, unstable = 0, rstn_low = 0, err1 = 0, err2 = 0;
    bit b1 [0:N*W-1];
    bit b2 [0:N*W-1];
    logic p_sc = 1'b0, p_sd1 = 1'b0, p_sd2 = 1'b0, p_load = 1'b0;
    fill(v.pattern);
    sel_f = v.fast;
    @(negedge clk);
    if (v.fast) start_f = 1'b1; else start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_f = 1'b0;
    for (int cyc = 1; cyc <= v.exp_lat + 12; cyc++) begin
      if (m_sc && !p_sc) begin
        if (rises < N*W) begin
          b1[rises] = m_sd1;
          b2[rises] = m_sd2;
        end
        rises++;
      end
      if (m_sc) hi_cyc++;
      if (m_sc && p_sc && (m_sd1 != p_sd1 || m_sd2 != p_sd2)) unstable++;
      if (m_sc && m_load) ovl++;
      if (m_load) load_cyc++;
      if (m_load && !p_load) load_pulses++;
      if (m_done) begin
        done_pulses++;
        if (lat < 0) lat = cyc;
      end
      if (!m_rstn) rstn_low++;
      if (m_busy != (lat < 0 || cyc == lat)) busy_err++;
      p_sc = m_sc; p_sd1 = m_sd1; p_sd2 = m_sd2; p_load = m_load;
      if (v.restart && (cyc == 5 || cyc == 1000)) begin
        if (v.fast) start_f = 1'b1; else start_s = 1'b1;
      end else begin
        start_s = 1'b0;
        start_f = 1'b0;
      end
      @(negedge clk);
    end
    start_s = 1'b0;
    start_f = 1'b0;
    // Chain 1 must see io[18]..io[0], chain 2 io[19]..io[37], each word MSB first.
    for (int i = 0; i < N*W; i++) begin
      int w = i / W;
      int b = W - 1 - (i % W);
      if (b1[i] != mem[N-1-w][b]) err1++;
      if (b2[i] != mem[N+w][b])   err2++;
    end
    check({v.name, ".latency"},     lat, v.exp_lat);
    check({v.name, ".clk_rises"},   rises, N*W);
    check({v.name, ".clk_high"},    hi_cyc, N*W*v.cd);
    check({v.name, ".load_cycles"}, load_cyc, 2*v.cd);
    check({v.name, ".load_pulses"}, load_pulses, 1);
    check({v.name, ".done_pulses"}, done_pulses, 1);
    check({v.name, ".busy_errs"},   busy_err, 0);
    check({v.name, ".clk_load_overlap"}, ovl, 0);
    check({v.name, ".data_unstable"},    unstable, 0);
    check({v.name, ".resetn_low"},  rstn_low, CLR_EN*2*v.cd);
    check({v.name, ".chain1_bits"}, err1, 0);
    check({v.name, ".chain2_bits"}, err2, 0);
  endtask

  initial begin
    vec_t vecs [4];
    int loads;
    vecs[0] = '{name:"incr",    pattern:0, fast:1'b0, restart:1'b0, cd:4, exp_lat:2023 + CLR_EN*8};
    vecs[1] = '{name:"ones",    pattern:1, fast:1'b0, restart:1'b0, cd:4, exp_lat:2023 + CLR_EN*8};
    vecs[2] = '{name:"restart", pattern:0, fast:1'b0, restart:1'b1, cd:4, exp_lat:2023 + CLR_EN*8};
    vecs[3] = '{name:"div1",    pattern:0, fast:1'b1, restart:1'b0, cd:1, exp_lat:535 + CLR_EN*2};

    fill(0);
    repeat (3) @(negedge clk);
    check("reset_outputs_s", int'({busy_s, done_s, a1_s, a2_s, sc_s, sl_s, srn_s, sd1_s, sd2_s}), 0);
    check("reset_outputs_f", int'({busy_f, done_f, a1_f, a2_f, sc_f, sl_f, srn_f, sd1_f, sd2_f}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("resetn_after_release", int'({srn_s, srn_f}), 3);
    check("idle_busy", int'({busy_s, busy_f}), 0);

    for (int i = 0; i < 4; i++) run_transfer(vecs[i]);

    // Abort at cycle 700 of a transfer, then confirm a fresh transfer still works.
    fill(0);
    sel_f = 1'b0;
    loads = 0;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (699) begin
      if (sl_s) loads++;
      @(negedge clk);
    end
    check("abort_busy_before", int'(busy_s), 1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", int'({busy_s, done_s, a1_s, a2_s, sc_s, sl_s, srn_s, sd1_s, sd2_s}), 0);
    repeat (4) begin
      @(negedge clk);
      if (sl_s) loads++;
    end
    check("abort_no_load", loads, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_transfer(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
